systolic_job_sequencer: RTL and testbench
=========================================

// Module: systolic_job_sequencer
// PURPOSE
//  Moore FSM that sequences one matrix-multiply job on systolic_array.
//  It drives restart_inputs, reset_accumulators, copy_accumulator_values_to_out_queue
//  and restart_out_queue, replacing the tie of all four to !ena.
//  It also tells the operand source when to stream, then frames the serial readout.
// PARAMETERS
//  SLICES   `COMPUTE_SLICES (4 if undefined)  array slices; W=SLICES, H=2*SLICES
//  KW       8                                 width of k_len (operand vectors per job)
//  derived: RESULTS=W*H=2*SLICES^2, IW=$clog2(RESULTS)
// PORTS
//  clk                   in  1   clock
//  reset                 in  1   synchronous, active-high reset
//  start                 in  1   job request; sampled only in IDLE
//  k_len                 in  KW  operand vectors per job, sampled with start
//  in_ready              out 1   source must present one operand byte pair this cycle
//  restart_inputs        out 1   to systolic_array
//  reset_accumulators    out 1   to systolic_array
//  copy_accumulator_values_to_out_queue out 1  to systolic_array
//  restart_out_queue     out 1   to systolic_array
//  out_valid             out 1   array `out` holds result out_index this cycle
//  out_index             out IW  index of result on `out` (0 = accumulator 0)
//  busy                  out 1   state != IDLE
//  done                  out 1   one-cycle pulse on last READ cycle
// BEHAVIOUR
//  One clock, synchronous active-high reset. All array controls decode from state only.
//  States: IDLE, LOAD, DRAIN, COPY, READ.
//  IDLE:
//   - restart_inputs=1, reset_accumulators=1, all other outputs 0.
//   - start=1 with k_len!=0 -> LOAD; k_len latched.
//   - start with k_len==0 is ignored: stay IDLE, no done.
//  LOAD:
//   - Lasts exactly k_len*SLICES cycles; in_ready=1, busy=1.
//   - Array slice_counter starts at 0 in the first LOAD cycle.
//   - The array cannot stall, so no backpressure: source supplies a beat every in_ready cycle.
//   - Beat counter is KW+$clog2(SLICES) bits; no wrap for k_len=2^KW-1.
//   - Then -> DRAIN.
//  DRAIN:
//   - Lasts SLICES cycles, letting the last vector rotate through all columns.
//   - Then -> COPY.
//  COPY:
//   - 1 cycle. copy_accumulator_values_to_out_queue=1, restart_out_queue=1,
//     reset_accumulators=1, restart_inputs=1.
//   - Then -> READ.
//  READ:
//   - Lasts RESULTS cycles; out_valid=1.
//   - out_index counts 0..RESULTS-1, one per cycle.
//   - done=1 on the cycle with out_index=RESULTS-1, then -> IDLE.
//  No other state asserts any array control.
//  start outside IDLE is ignored, not queued: next job may start 1 cycle after done.
//  Latency from start (cycle 0): LOAD 1..kS, DRAIN kS+1..kS+S, COPY kS+S+1,
//   READ from kS+S+2 for RESULTS cycles (k=k_len, S=SLICES).
//  Reset in any state:
//   - next cycle IDLE, counters 0, out_index=0.
//   - in_ready=out_valid=done=busy=0.
//   - restart_inputs=reset_accumulators=1; a partial job is discarded.
//  Simultaneous reset and start: reset wins.
// TESTING (SLICES=2: W=2, H=4, RESULTS=8)
//  1. reset 3 cycles, start=0 -> busy=0, in_ready=0, out_valid=0, restart_inputs=1, reset_accumulators=1.
//  2. start@0, k_len=3 -> in_ready 1..6, DRAIN 7..8, copy pulse @9,
//     out_valid 10..17 with out_index 0..7, done @17 only, busy=0 @18.
//  3. Full datapath: k_len=1, fp4 all 4'b0001, i8 operands 1 -> all 8 results=2;
//     out byte = 2>>11 = 0; repeat with i8=127, fp4=4'b0111 -> each result 16256, out 7.
//  4. start held high through job 2 -> exactly one job; second starts @18; start @5 not queued.
//  5. k_len=0 start -> stays IDLE; k_len=255 -> LOAD lasts 510 cycles exactly.
//  6. reset asserted @4 (LOAD) and again mid-READ -> IDLE next cycle, no done, no copy pulse;
//     following job gives correct results.

Source files
------------

// File: rtl/systolic_job_sequencer.sv
// systolic_job_sequencer
//   Moore FSM that sequences one matrix-multiply job on systolic_array.
//   It drives the four array controls (restart_inputs, reset_accumulators,
//   copy_accumulator_values_to_out_queue, restart_out_queue), tells the
//   operand source when to stream, and then frames the serial result readout.
//
//   Job phases: IDLE -> LOAD (k_len*SLICES cycles) -> DRAIN (SLICES cycles)
//               -> COPY (1 cycle) -> READ (RESULTS cycles) -> IDLE
//
// Parameters
//   SLICES  array slices (W=SLICES, H=2*SLICES)
//   KW      width of k_len
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start, k_len        job request and operand vector count (IDLE only)
//   in_ready            source presents one operand byte pair this cycle
//   restart_inputs, reset_accumulators,
//   copy_accumulator_values_to_out_queue, restart_out_queue
//                       systolic_array controls
//   out_valid, out_index array `out` holds result out_index this cycle
//   busy                not idle
//   done                one-cycle pulse on the last READ cycle

`ifndef COMPUTE_SLICES
`define COMPUTE_SLICES 4
`endif

module systolic_job_sequencer #(
  parameter  int SLICES  = `COMPUTE_SLICES,
  parameter  int KW      = 8,
  localparam int RESULTS = 2 * SLICES * SLICES,
  localparam int IW      = $clog2(RESULTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  output logic          in_ready,
  output logic          restart_inputs,
  output logic          reset_accumulators,
  output logic          copy_accumulator_values_to_out_queue,
  output logic          restart_out_queue,
  output logic          out_valid,
  output logic [IW-1:0] out_index,
  output logic          busy,
  output logic          done
);

  // Beat counter must hold k_len*SLICES-1 for the largest k_len.
  localparam int SW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int CW = KW + SW;

  localparam logic [CW-1:0] S_CW       = CW'(SLICES);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(SLICES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(RESULTS - 1);
  localparam logic [IW-1:0] PRE_IDX    = IW'(RESULTS - 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    COPY,
    READ
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [KW-1:0]   k_q;
  logic [CW-1:0]   load_last;

  always_comb begin
    load_last = '0;
    load_last = (CW'(k_q) * S_CW) - CW'(1);
  end

  // Outputs are registered: each transition loads the values that belong
  // to the state being entered, so they stay a pure function of state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                                <= IDLE;
      cnt                                  <= '0;
      k_q                                  <= '0;
      in_ready                             <= 1'b0;
      restart_inputs                       <= 1'b1;
      reset_accumulators                   <= 1'b1;
      copy_accumulator_values_to_out_queue <= 1'b0;
      restart_out_queue                    <= 1'b0;
      out_valid                            <= 1'b0;
      out_index                            <= '0;
      busy                                 <= 1'b0;
      done                                 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (k_len != '0)) begin
            state              <= LOAD;
            k_q                <= k_len;
            cnt                <= '0;
            in_ready           <= 1'b1;
            busy               <= 1'b1;
            restart_inputs     <= 1'b0;
            reset_accumulators <= 1'b0;
          end
        end

        LOAD: begin
          if (cnt == load_last) begin
            state    <= DRAIN;
            cnt      <= '0;
            in_ready <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state                                <= COPY;
            cnt                                  <= '0;
            restart_inputs                       <= 1'b1;
            reset_accumulators                   <= 1'b1;
            copy_accumulator_values_to_out_queue <= 1'b1;
            restart_out_queue                    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        COPY: begin
          state                                <= READ;
          restart_inputs                       <= 1'b0;
          reset_accumulators                   <= 1'b0;
          copy_accumulator_values_to_out_queue <= 1'b0;
          restart_out_queue                    <= 1'b0;
          out_valid                            <= 1'b1;
          out_index                            <= '0;
          done                                 <= (RESULTS == 1);
        end

        READ: begin
          if (out_index == LAST_IDX) begin
            state              <= IDLE;
            out_valid          <= 1'b0;
            out_index          <= '0;
            done               <= 1'b0;
            busy               <= 1'b0;
            restart_inputs     <= 1'b1;
            reset_accumulators <= 1'b1;
          end else begin
            out_index <= out_index + IW'(1);
            // done is registered, so it is raised one cycle ahead of the last index
            done      <= (out_index == PRE_IDX);
          end
        end

        default: begin
          state                                <= IDLE;
          cnt                                  <= '0;
          in_ready                             <= 1'b0;
          restart_inputs                       <= 1'b1;
          reset_accumulators                   <= 1'b1;
          copy_accumulator_values_to_out_queue <= 1'b0;
          restart_out_queue                    <= 1'b0;
          out_valid                            <= 1'b0;
          out_index                            <= '0;
          busy                                 <= 1'b0;
          done                                 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_job_sequencer.sv
// Directed bench for systolic_job_sequencer with SLICES=2 (RESULTS=8).
// Cycle 0 is the cycle in which start is presented; outputs for cycle n are
// sampled on the falling edge inside cycle n and compared, as one packed
// vector, against the timeline derived from k_len and SLICES.

module tb_systolic_job_sequencer;

  localparam int S  = 2;
  localparam int R  = 2 * S * S;
  localparam int KW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [KW-1:0] k_len;
  logic          in_ready;
  logic          restart_inputs;
  logic          reset_accumulators;
  logic          copy_accumulator_values_to_out_queue;
  logic          restart_out_queue;
  logic          out_valid;
  logic [IW-1:0] out_index;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  systolic_job_sequencer #(.SLICES(S), .KW(KW)) dut (
    .clk                                  (clk),
    .reset                                (reset),
    .start                                (start),
    .k_len                                (k_len),
    .in_ready                             (in_ready),
    .restart_inputs                       (restart_inputs),
    .reset_accumulators                   (reset_accumulators),
    .copy_accumulator_values_to_out_queue (copy_accumulator_values_to_out_queue),
    .restart_out_queue                    (restart_out_queue),
    .out_valid                            (out_valid),
    .out_index                            (out_index),
    .busy                                 (busy),
    .done                                 (done)
  );

  always #5 clk = ~clk;

  // Vector layout: {busy, in_ready, restart_inputs, reset_accumulators,
  //                 copy, restart_out_queue, out_valid, done, out_index}
  localparam logic [10:0] IDLE_V  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
  localparam logic [10:0] LOAD_V  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
  localparam logic [10:0] DRAIN_V = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
  localparam logic [10:0] COPY_V  = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] obs();
    return {busy, in_ready, restart_inputs, reset_accumulators,
            copy_accumulator_values_to_out_queue, restart_out_queue,
            out_valid, done, out_index};
  endfunction

  // Expected outputs in cycle n of a job started in cycle 0 with k vectors.
  function automatic logic [10:0] exp_vec(input int k, input int n);
    int ks;
    int i;
    ks = k * S;
    if (k == 0 || n < 1)        return IDLE_V;
    if (n <= ks)                return LOAD_V;
    if (n <= ks + S)            return DRAIN_V;
    if (n == ks + S + 1)        return COPY_V;
    if (n <= ks + S + 1 + R) begin
      i = n - (ks + S + 2);
      return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (i == R - 1), 3'(i)};
    end
    return IDLE_V;
  endfunction

  // Present start with k in the current cycle (cycle 0 of the job).
  task automatic kick(input int k);
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
  endtask

  // Check cycles from_n..to_n; then drive start/reset for that cycle.
  task automatic watch(input int k, input int from_n, input int to_n,
                       input int pulse_at, input bit hold, input int rst_at,
                       input string tag);
    logic [10:0] e;
    for (int n = from_n; n <= to_n; n++) begin
      @(negedge clk);
      e = (rst_at > 0 && n > rst_at) ? IDLE_V : exp_vec(k, n);
      check($sformatf("%s_c%0d", tag, n), 32'(obs()), 32'(e));
      start = hold || (n == pulse_at);
      reset = (n == rst_at);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    k_len = '0;

    // 1. reset state
    repeat (3) @(negedge clk);
    check("reset_idle", 32'(obs()), 32'(IDLE_V));
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(obs()), 32'(IDLE_V));

    // reset and start together: reset wins
    reset = 1'b1; start = 1'b1; k_len = 8'd3;
    @(negedge clk);
    check("reset_beats_start", 32'(obs()), 32'(IDLE_V));
    reset = 1'b0; start = 1'b0;

    // 2. basic job, k_len=3
    kick(3);
    watch(3, 1, 18, 0, 1'b0, 0, "job3");

    // 4a. start pulsed mid-LOAD is not queued
    kick(3);
    watch(3, 1, 22, 5, 1'b0, 0, "noqueue");

    // 4b. start held through a job: next job starts from cycle 18
    kick(3);
    watch(3, 1, 18, 0, 1'b1, 0, "held1");
    watch(3, 1, 20, 0, 1'b0, 0, "held2");

    // 5. k_len=0 ignored, k_len=255 loads for 510 cycles
    kick(0);
    watch(0, 1, 4, 0, 1'b0, 0, "k0");
    kick(255);
    watch(255, 1, 522, 0, 1'b0, 0, "k255");

    // 6. reset during LOAD, reset during READ, then a clean job
    kick(3);
    watch(3, 1, 8, 0, 1'b0, 4, "rstload");
    kick(3);
    watch(3, 1, 20, 0, 1'b0, 13, "rstread");
    kick(3);
    watch(3, 1, 18, 0, 1'b0, 0, "after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
